tim_channel: RTL and testbench

Single compare/PWM channel of the general-purpose timer. Samples the timer's shared 16-bit count every `clk` and compares it against a per-channel compare value, producing a registered PWM output and a one-cycle compare-match pulse. Two instances sit beside the timer counter, one per channel (CCR1, CCR2). The block does not own the counter, the prescaler or the auto-reload logic.

---
 rtl/tim_channel_if.sv | 25 ++
 rtl/tim_channel.sv | 59 +++++
 tb/tb_tim_channel.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tim_channel_if.sv
// Signal bundle between the timer core and one compare/PWM channel.
// There is no handshake: the channel samples every input on every clk edge.
interface tim_channel_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] tim_cnt;
  logic [WIDTH-1:0] tim_ccr;
  logic             mode;
  logic             polarity;
  logic             pwm_out;
  logic             cc_flag;

  // Timer core side
  modport master (
    output en, tim_cnt, tim_ccr, mode, polarity,
    input  pwm_out, cc_flag
  );

  // Channel side
  modport slave (
    input  en, tim_cnt, tim_ccr, mode, polarity,
    output pwm_out, cc_flag
  );
endinterface

// File: rtl/tim_channel.sv
// Single compare/PWM channel: registered PWM level plus a one-cycle compare-match pulse.
// Define TIM_CH_PRELOAD_EN to take the compare value from a shadow register updated at period start.
module tim_channel #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  tim_channel_if.slave bus
);
  logic [WIDTH-1:0] w_ccr_act;
  logic [WIDTH-1:0] r_cnt_prev;
  logic             r_en_d;
  logic             r_pwm;
  logic             r_cc;
  logic             w_raw;
  logic             w_match;

`ifdef TIM_CH_PRELOAD_EN
  logic [WIDTH-1:0] r_ccr_shadow;

  // CCR writes land only at count zero (or while disabled) so a period never sees a half-updated duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ccr_shadow <= '0;
    end else if ((bus.tim_cnt == '0) || !bus.en) begin
      r_ccr_shadow <= bus.tim_ccr;
    end
  end

  assign w_ccr_act = r_ccr_shadow;
`else
  assign w_ccr_act = bus.tim_ccr;
`endif

  assign w_raw = bus.mode ? (bus.tim_cnt >= w_ccr_act) : (bus.tim_cnt < w_ccr_act);

  // r_en_d gates the first enabled cycle, where r_cnt_prev still holds a stale count.
  assign w_match = bus.en && r_en_d && (bus.tim_cnt == w_ccr_act) &&
                   (bus.tim_cnt != r_cnt_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_prev <= '0;
      r_en_d     <= 1'b0;
      r_pwm      <= 1'b0;
      r_cc       <= 1'b0;
    end else begin
      r_en_d <= bus.en;
      if (bus.en) begin
        r_cnt_prev <= bus.tim_cnt;
      end
      r_pwm <= bus.en ? (w_raw ^ bus.polarity) : 1'b0;
      r_cc  <= w_match;
    end
  end

  assign bus.pwm_out = r_pwm;
  assign bus.cc_flag = r_cc;
endmodule

// File: tb/tb_tim_channel.sv
// Directed bench for tim_channel in its default (non-preload) build.
module tb_tim_channel;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tim_channel_if #(.WIDTH(WIDTH)) bus ();

  tim_channel #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic exp_pwm, input logic exp_cc);
    checks++;
    assert (bus.pwm_out === exp_pwm) else begin
      errors++;
      $error("FAIL %s pwm_out observed %b expected %b", tag, bus.pwm_out, exp_pwm);
    end
    checks++;
    assert (bus.cc_flag === exp_cc) else begin
      errors++;
      $error("FAIL %s cc_flag observed %b expected %b", tag, bus.cc_flag, exp_cc);
    end
  endtask

  // Apply a count, take one edge, check the registered result just after it.
  task automatic cyc(input logic [WIDTH-1:0] cnt, input logic exp_pwm, input logic exp_cc,
                     input string tag);
    bus.tim_cnt = cnt;
    @(posedge clk);
    #1;
    check(tag, exp_pwm, exp_cc);
  endtask

  logic [7:0] exp_pwm_v;
  logic [7:0] exp_cc_v;

  initial begin
    checks = 0;
    errors = 0;
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.mode     = 1'b0;
    bus.polarity = 1'b0;
    bus.tim_cnt  = 16'd5;
    bus.tim_ccr  = 16'd10;
    #3;
    check("reset_hold", 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    cyc(16'd5, 1'b1, 1'b0, "reset_release");

    // Asynchronous reset mid-period clears outputs without an edge
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0, polarity 0 sweep
    bus.tim_ccr = 16'd3;
    exp_pwm_v = 8'b0000_0111;
    exp_cc_v  = 8'b0000_1000;
    for (int i = 0; i < 8; i++)
      cyc(WIDTH'(i), exp_pwm_v[i], exp_cc_v[i], $sformatf("m0_sweep_%0d", i));

    // Mode 1 with inverted polarity gives the same waveform
    bus.mode     = 1'b1;
    bus.polarity = 1'b1;
    for (int i = 0; i < 8; i++)
      cyc(WIDTH'(i), exp_pwm_v[i], exp_cc_v[i], $sformatf("m1p1_sweep_%0d", i));

    // Stalled count at the compare value: one pulse only
    bus.mode     = 1'b0;
    bus.polarity = 1'b0;
    cyc(16'd2, 1'b1, 1'b0, "stall_pre");
    for (int i = 0; i < 4; i++)
      cyc(16'd3, 1'b0, (i == 0), $sformatf("stall_%0d", i));

    // ccr = 0, mode 0: never active; the count arriving at 0 still matches
    bus.tim_ccr = 16'd0;
    cyc(16'd0, 1'b0, 1'b1, "ccr0_cnt0");
    cyc(16'd1, 1'b0, 1'b0, "ccr0_cnt1");
    cyc(16'd5, 1'b0, 1'b0, "ccr0_cnt5");

    // ccr = 0, mode 1: always active
    bus.mode = 1'b1;
    cyc(16'd7, 1'b1, 1'b0, "ccr0_m1_cnt7");
    cyc(16'd0, 1'b1, 1'b1, "ccr0_m1_cnt0");
    bus.mode = 1'b0;

    // ccr all-ones
    bus.tim_ccr = 16'hFFFF;
    cyc(16'hFFFE, 1'b1, 1'b0, "ccr_max_fffe");
    cyc(16'hFFFF, 1'b0, 1'b1, "ccr_max_ffff");

    // Disabled: output forced low even with inverted polarity, no pulse
    bus.tim_ccr  = 16'd3;
    bus.en       = 1'b0;
    bus.polarity = 1'b1;
    cyc(16'd3, 1'b0, 1'b0, "dis_cnt3");
    cyc(16'd5, 1'b0, 1'b0, "dis_cnt5");

    // Enabling on a matching count must not pulse; down-count match later does
    bus.en       = 1'b1;
    bus.polarity = 1'b0;
    cyc(16'd3, 1'b0, 1'b0, "en_rise_cnt3");
    cyc(16'd4, 1'b0, 1'b0, "en_cnt4");
    cyc(16'd3, 1'b0, 1'b1, "down_cnt3");
    cyc(16'd2, 1'b1, 1'b0, "down_cnt2");

    // Direct compare: a CCR write 3 -> 6 applies on the next edge
    cyc(16'd4, 1'b0, 1'b0, "ccr_chg_pre");
    bus.tim_ccr = 16'd6;
    cyc(16'd4, 1'b1, 1'b0, "ccr_chg_post");
    cyc(16'd6, 1'b0, 1'b1, "ccr_chg_cnt6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
